// File: rtl/julia_pkg.sv
// Shared constants, state encoding and helpers for the Julia frame path.
package julia_pkg;

    localparam logic [31:0] FX_ONE      = 32'h0001_0000;
    localparam logic [31:0] FX_TWO      = 32'h0002_0000;

    localparam logic [31:0] X_START_DEF = 32'hFFFE_0000;
    localparam logic [31:0] Y_START_DEF = 32'h0001_8000;
    localparam logic [31:0] STEP_DEF    = 32'h0000_019A;

    localparam int unsigned ITER_MAX    = 256;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned PIX_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    // Map an iteration count (0..ITER_MAX) onto an 8-bit pixel value.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic [8:0] v);
        return (v >= 9'(ITER_MAX - 1)) ? 8'hFF : v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/julia_coord_gen.sv
// Raster counters and incremental Q16.16 coordinate accumulators.
module julia_coord_gen
    import julia_pkg::*;
#(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter logic [31:0] X_START = X_START_DEF,
    parameter logic [31:0] Y_START = Y_START_DEF,
    parameter logic [31:0] STEP    = STEP_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     advance,
    output logic signed [31:0]       x_com,
    output logic signed [31:0]       y_com,
    output logic [ADDR_W-1:0]        addr,
    output logic                     last
);

    localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_end;

    assign col_end = (col == COL_W'(H_RES - 1));
    assign last    = col_end && (row == ROW_W'(V_RES - 1));

    // Walk the frame in raster order; x resets per line, y steps down per line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            x_com <= $signed(X_START);
            y_com <= $signed(Y_START);
        end else if (load) begin
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            x_com <= $signed(X_START);
            y_com <= $signed(Y_START);
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (!col_end) begin
                col   <= col + COL_W'(1);
                x_com <= x_com + $signed(STEP);
            end else begin
                col   <= '0;
                row   <= row + ROW_W'(1);
                x_com <= $signed(X_START);
                y_com <= y_com - $signed(STEP);
            end
        end
    end

endmodule

// File: rtl/julia_scan.sv
// Frame-scan dispatcher: feeds pixel coordinates to the free-running Julia
// iterator and turns each reported iteration count into a framebuffer write.
// Optional build macro JULIA_SCAN_PERF_EN adds the frame_cycles counter output.
module julia_scan
    import julia_pkg::*;
#(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter logic [31:0] X_START = X_START_DEF,
    parameter logic [31:0] Y_START = Y_START_DEF,
    parameter logic [31:0] STEP    = STEP_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic signed [31:0]       x_com,
    output logic signed [31:0]       y_com,
    input  logic                     iter_ready,
    input  logic [8:0]               iter_val,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [PIX_W-1:0]         wr_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
`ifdef JULIA_SCAN_PERF_EN
    ,
    output logic [31:0]              frame_cycles
`endif
);

    scan_state_t       state_q;
    scan_state_t       state_d;
    logic              ready_q;
    logic              evt_c;
    logic              load_c;
    logic              advance_c;
    logic              wbuf_load_c;
    logic              done_c;
    logic              last;
    logic [ADDR_W-1:0] addr;

    julia_coord_gen #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .X_START (X_START),
        .Y_START (Y_START),
        .STEP    (STEP)
    ) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_c),
        .advance (advance_c),
        .x_com   (x_com),
        .y_com   (y_com),
        .addr    (addr),
        .last    (last)
    );

    // A new result is the rising edge of the iterator's two-cycle ready.
    assign evt_c = iter_ready && !ready_q;

    // Ready history for result edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= iter_ready;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        load_c      = 1'b0;
        advance_c   = 1'b0;
        wbuf_load_c = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PRIME;
                    load_c  = 1'b1;
                end
            end
            PRIME: begin
                // First result predates the frame; pixel 0 stays held so the
                // iterator reloads it on this result.
                if (evt_c) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (evt_c) begin
                    wbuf_load_c = 1'b1;
                    if (last) begin
                        state_d = DRAIN;
                    end else begin
                        advance_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!wr_valid || wr_ready) begin
                    state_d = DONE;
                    done_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single-entry write buffer, status outputs and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= done_c;
            busy       <= (state_d == PRIME) || (state_d == SCAN);
            if (wbuf_load_c && (!wr_valid || wr_ready)) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= clamp_pix(iter_val);
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
            if (load_c) begin
                overrun <= 1'b0;
            end else if (wbuf_load_c && wr_valid && !wr_ready) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef JULIA_SCAN_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cyc_nxt;

    assign cyc_nxt = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 32'd1;

    // Saturating clock count from start acceptance, latched at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt      <= '0;
            frame_cycles <= '0;
        end else if (load_c) begin
            cyc_cnt      <= '0;
            frame_cycles <= '0;
        end else if ((state_q == PRIME) || (state_q == SCAN) || (state_q == DRAIN)) begin
            cyc_cnt <= cyc_nxt;
            if (done_c) begin
                frame_cycles <= cyc_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_julia_scan.sv
// Bench for julia_scan on a 4x2 frame with a free-running iterator model.
module tb_julia_scan;
    import julia_pkg::*;

    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam int          NPIX = H * V;
    localparam logic [31:0] XS   = 32'hFFFE_0000;
    localparam logic [31:0] YS   = 32'h0001_8000;
    localparam logic [31:0] ST   = 32'h0000_8000;
    localparam int          PER  = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [31:0] x_com;
    logic signed [31:0] y_com;
    logic               iter_ready = 1'b0;
    logic [8:0]         iter_val = '0;
    logic               wr_valid;
    logic               wr_ready = 1'b1;
    logic [18:0]        wr_addr;
    logic [7:0]         wr_data;
    logic               busy;
    logic               frame_done;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    julia_scan #(
        .H_RES   (H),
        .V_RES   (V),
        .X_START (XS),
        .Y_START (YS),
        .STEP    (ST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_com      (x_com),
        .y_com      (y_com),
        .iter_ready (iter_ready),
        .iter_val   (iter_val),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- iterator model ----------------
    logic [31:0] z_x = XS;
    logic [31:0] z_y = YS;
    logic [31:0] res_x = XS;
    logic [31:0] res_y = YS;
    int          ph = PER - 1;
    bit          mode256 = 1'b0;

    // Iteration count derived from the coordinate actually loaded: pixel index + 10.
    function automatic logic [8:0] iter_result(input logic [31:0] zx, input logic [31:0] zy);
        int col;
        int row;
        if (mode256) return 9'd256;
        col = int'($signed(zx - XS)) / int'(ST);
        row = int'($signed(YS - zy)) / int'(ST);
        return 9'(row * H + col + 10);
    endfunction

    initial begin : iterator
        forever begin
            @(negedge clk);
            if (ph == 1) begin
                z_x = x_com;
                z_y = y_com;
            end
            @(posedge clk);
            #1;
            ph = (ph + 1) % PER;
            iter_ready = (ph <= 1);
            if (ph == 0) begin
                iter_val = iter_result(z_x, z_y);
                res_x    = z_x;
                res_y    = z_y;
            end
        end
    end

    // ---------------- behavioural model ----------------
    int          m_ph;     // 0 idle/done, 1 prime, 2 scan, 3 drain
    int          m_pix;
    bit          m_pend, m_ovr, m_done, m_rq;
    logic [18:0] m_paddr;
    logic [7:0]  m_pdata;

    task automatic model_reset();
        m_ph = 0; m_pix = 0; m_pend = 0; m_ovr = 0; m_done = 0; m_rq = 0;
        m_paddr = '0; m_pdata = '0;
    endtask

    task automatic model_step();
        bit evt;
        bit n_pend;
        bit n_done;
        evt    = iter_ready && !m_rq;
        n_pend = m_pend && !wr_ready;
        n_done = 0;
        case (m_ph)
            0: if (start) begin m_ph = 1; m_pix = 0; m_ovr = 0; end
            1: if (evt) m_ph = 2;
            2: if (evt) begin
                   if (n_pend) m_ovr = 1;
                   else begin
                       n_pend  = 1;
                       m_paddr = 19'(m_pix);
                       m_pdata = (iter_val > 9'd255) ? 8'hFF : iter_val[7:0];
                   end
                   if (m_pix == NPIX - 1) m_ph = 3;
                   else m_pix++;
               end
            3: if (!m_pend || wr_ready) begin m_ph = 0; n_done = 1; end
            default: m_ph = 0;
        endcase
        m_pend = n_pend;
        m_done = n_done;
        m_rq   = iter_ready;
    endtask

    function automatic logic [31:0] mx(input int p);
        return XS + 32'((p % H) * int'(ST));
    endfunction
    function automatic logic [31:0] my(input int p);
        return YS - 32'((p / H) * int'(ST));
    endfunction
    function automatic logic [7:0] exp_data(input logic [18:0] a);
        int v;
        v = mode256 ? 256 : int'(a) + 10;
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    logic [31:0] lit_x [4] = '{32'hFFFE_0000, 32'hFFFE_8000, 32'hFFFF_0000, 32'hFFFF_8000};
    logic [31:0] lit_y [2] = '{32'h0001_8000, 32'h0001_0000};

    int wr_cnt = 0;
    int done_cnt = 0;
    int nxt_addr = 0;
    bit coord_chk = 0;
    bit seq_chk = 0;

    // Per-cycle comparison against the model plus write scoreboard.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        chk("x_com", x_com, mx(m_pix));
        chk("y_com", y_com, my(m_pix));
        chk("wr_valid", 32'(wr_valid), 32'(m_pend));
        chk("wr_addr", 32'(wr_addr), 32'(m_paddr));
        chk("wr_data", 32'(wr_data), 32'(m_pdata));
        chk("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (wr_valid && wr_ready) begin
            wr_cnt++;
            chk("data_by_addr", 32'(wr_data), 32'(exp_data(wr_addr)));
            if (seq_chk) begin
                chk("addr_order", 32'(wr_addr), 32'(nxt_addr));
                nxt_addr++;
            end
            if (coord_chk) begin
                chk("coord_x_lit", res_x, lit_x[int'(wr_addr) % H]);
                chk("coord_y_lit", res_y, lit_y[int'(wr_addr) / H]);
            end
        end
        if (frame_done) done_cnt++;
        if (rst_n) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt == d0 && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        chk({tag, "_done_in_time"}, 32'(cyc < 2000), 32'd1);
    endtask

    task automatic run_frame(input int exp_writes, input string tag);
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        nxt_addr = 0;
        pulse_start();
        wait_done(d0, tag);
        tick(PER * 3);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_writes));
        chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int w0;
        int d0;
        int cyc;
        tick(3);
        chk("rst_x_lit", x_com, 32'hFFFE_0000);
        chk("rst_y_lit", y_com, 32'h0001_8000);
        chk("rst_wr_valid_lit", 32'(wr_valid), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Frame with count = addr+10 and coordinate checks.
        coord_chk = 1; seq_chk = 1;
        run_frame(NPIX, "frame1");
        coord_chk = 0;
        chk("f1_overrun_lit", 32'(overrun), 32'd0);
        chk("f1_final_x_lit", x_com, 32'hFFFF_8000);
        chk("f1_final_y_lit", y_com, 32'h0001_0000);
        chk("f1_busy_lit", 32'(busy), 32'd0);

        // Saturated iteration count.
        mode256 = 1;
        run_frame(NPIX, "sat");
        mode256 = 0;

        // Write port stalled across two results.
        seq_chk = 0;
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start();
        cyc = 0;
        while (!wr_valid && cyc < 200) begin tick(1); cyc++; end
        chk("ovr_first_valid", 32'(wr_valid), 32'd1);
        wr_ready = 1'b0;
        tick(10);
        chk("ovr_set_lit", 32'(overrun), 32'd1);
        wr_ready = 1'b1;
        wait_done(d0, "ovr");
        chk("ovr_writes_lit", 32'(wr_cnt - w0), 32'd7);
        chk("ovr_sticky_lit", 32'(overrun), 32'd1);
        tick(5);
        pulse_start();
        chk("ovr_cleared_lit", 32'(overrun), 32'd0);
        d0 = done_cnt;
        wait_done(d0, "ovr_next");

        // Reset mid-scan at addr 3.
        pulse_start();
        cyc = 0;
        while (!(wr_valid && wr_addr == 19'd3) && cyc < 200) begin tick(1); cyc++; end
        chk("mid_addr3_seen", 32'(wr_addr), 32'd3);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_lit", 32'(wr_valid), 32'd0);
        chk("mid_rst_addr_lit", 32'(wr_addr), 32'd0);
        chk("mid_rst_busy_lit", 32'(busy), 32'd0);
        chk("mid_rst_x_lit", x_com, 32'hFFFE_0000);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        seq_chk = 1;
        run_frame(NPIX, "after_rst");

        // Start coincident with an event in IDLE, plus start while busy.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        cyc = 0;
        while (ph != 0 && cyc < 3 * PER) begin tick(1); cyc++; end
        chk("coinc_sync", 32'(ph), 32'd0);
        w0 = wr_cnt; d0 = done_cnt; nxt_addr = 0;
        pulse_start();
        tick(10);
        pulse_start();
        tick(15);
        pulse_start();
        wait_done(d0, "coinc");
        tick(40);
        chk("coinc_writes", 32'(wr_cnt - w0), 32'(NPIX));
        chk("coinc_one_done", 32'(done_cnt - d0), 32'd1);
        chk("coinc_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/julia_scan.md
# julia_scan

Frame-scan dispatcher that drives the Julia iterator from the initiator side. It walks every pixel of a frame in raster order and maps each pixel to a Q16.16 complex-plane coordinate presented on `x_com`/`y_com`. It captures each iteration count the iterator reports with `ready`/`fin_iter` and issues one framebuffer write per pixel. It sits between the iterator and the framebuffer write port, under control of the top-level frame sequencer.

## Interface
Parameters:
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `X_START`, 32'hFFFE_0000: Q16.16 real coordinate of column 0 (-2.0).
- `Y_START`, 32'h0001_8000: Q16.16 imaginary coordinate of row 0 (+1.5).
- `STEP`, 32'h0000_019A: Q16.16 distance between adjacent pixels (~1/160).

Ports:
- `clk` in 1: system clock. All logic runs in this one clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse that begins a frame. Ignored unless the block is in IDLE or DONE.
- `x_com` out 32 signed: Q16.16 real coordinate presented to the iterator.
- `y_com` out 32 signed: Q16.16 imaginary coordinate presented to the iterator.
- `iter_ready` in 1: iterator `ready`. The iterator holds it high for 2 cycles per result.
- `iter_val` in 9: iterator `fin_iter`, range 0..256.
- `wr_valid` out 1: framebuffer write request.
- `wr_ready` in 1: framebuffer accepts a write on any cycle where `wr_valid && wr_ready`.
- `wr_addr` out 19: linear pixel address, `row*H_RES+col`.
- `wr_data` out 8: pixel value.
- `busy` out 1: high in PRIME and SCAN.
- `frame_done` out 1: one-cycle pulse after the last write of a frame is accepted.
- `overrun` out 1: sticky error flag. Cleared on `start`.

## Operation
- The iterator runs freely and cannot be stalled. It reloads its z from `x_com`/`y_com` on the second clock edge after `ready` rises.
- Result detection: `evt = iter_ready && !ready_q`, where `ready_q` is `iter_ready` registered.
- States:
  - IDLE→PRIME on `start`. Load `x_com=X_START`, `y_com=Y_START`, col=row=0, addr=0. Clear `overrun`.
  - PRIME: hold the pixel-0 coordinates. On the first `evt`, discard the result and go to SCAN. This result may have been computed from pre-start coordinates. Because pixel 0 is still held, the iterator reloads pixel 0 on this reload.
  - SCAN: on each `evt`:
    - Load the write buffer with `wr_addr`=addr and `wr_data=min(iter_val,255)`, and set `wr_valid`.
    - In the same edge, advance to the next pixel. If col<H_RES-1: col++, `x_com+=STEP`. Otherwise: col=0, `x_com=X_START`, row++, `y_com-=STEP`. addr++ in both cases.
    - The `evt` for the last pixel (addr=H_RES*V_RES-1) moves the state to DRAIN. Coordinates do not advance on the last pixel.
  - DRAIN: wait for the pending write to be accepted, then go to DONE and pulse `frame_done`.
  - DONE behaves like IDLE: `evt` is ignored and `start` restarts the frame.
- Write buffer holds one entry, and `wr_valid` drops on acceptance.
  - If `evt` occurs while the entry is still pending and `wr_ready` is low: keep the old entry, drop the new result, advance coordinates normally, set `overrun`.
  - If `wr_ready` is high in that same cycle: accept the old entry and load the new one, with no overrun.
- All coordinate arithmetic is 32-bit two's complement and wraps with no saturation.

## Timing
- Reset values: `x_com=X_START`, `y_com=Y_START`, `wr_valid=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `frame_done=0`, `overrun=0`, state IDLE.
- Taking `iter_ready` rise at edge N:
  - `evt` is seen at edge N+1.
  - `wr_valid` and the new `x_com` are visible after edge N+1.
  - The iterator reloads the new coordinate at edge N+2.
- `start` in the same cycle as `evt` while in IDLE: `evt` is ignored and the block enters PRIME.
- `start` while `busy` is ignored.
- `rst_n` low at any time returns the block to IDLE immediately with reset values. No `frame_done` is issued for the aborted frame.

## Configuration
- `JULIA_SCAN_PERF_EN` defined:
  - Adds output `frame_cycles` [31:0], which counts clocks from `start` acceptance to `frame_done`.
  - The counter saturates at all-ones and is latched at `frame_done`. The latched value is held until the next `start`.
  - Reset value is 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `julia_pkg`:
  - Q16.16 constants `FX_ONE` and `FX_TWO`.
  - Default `X_START`/`Y_START`/`STEP` values.
  - State encoding `scan_state_t`: IDLE, PRIME, SCAN, DRAIN, DONE.
  - `ITER_MAX=256`.
- One natural sub-module, `julia_coord_gen`: col/row/addr counters plus the incremental coordinate accumulators, with `load` and `advance` inputs and a `last` output.
- The FSM and the write buffer stay in `julia_scan`.

## Test plan
All scenarios use a bench iterator model with the real 2-cycle `ready` protocol and reload on the second edge. Scenario parameters are H_RES=4, V_RES=2, STEP=32'h0000_8000.
- Reset, then `start`, with the model returning iteration count = addr+10: 8 writes with addresses 0..7 and data 10..17, then one `frame_done` pulse, `overrun=0`. The PRIME result is never written.
- Model captures the reloaded coordinates: sequence x = FFFE_0000, FFFE_8000, FFFF_0000, FFFF_8000 repeated per row, y = 0001_8000 then 0001_0000.
- Model returns 256 for every pixel: every `wr_data` = 8'hFF.
- `wr_ready` held low across two results: first entry kept, second dropped, `overrun=1` until the next `start`, coordinates still advance.
- `rst_n` pulsed low mid-SCAN (addr=3): outputs at reset values on the next cycle and no `frame_done`. A following `start` produces a complete frame from addr 0.
- `start` coincident with an `evt` in IDLE, plus `start` pulsed while busy: exactly one frame of 8 writes is produced.
